// File: rtl/shift_frame_ctrl.sv
// -----------------------------------------------------------------------------
// shift_frame_ctrl
//   Serial-to-parallel frame capture controller. A frame of len+1 bits is
//   shifted in MSB-first while sbit_vld is high, then presented right-aligned
//   on word with word_vld until the consumer accepts it (word_vld && word_rdy).
//   A capture stalled for TIMEOUT consecutive idle cycles is abandoned.
//
// Parameters
//   TIMEOUT   max idle cycles between accepted bits in SHIFT (1..255)
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   start     begin (or restart) a frame capture
//   sdata     serial data bit
//   sbit_vld  qualifies sdata this cycle
//   len       frame length minus one, sampled on entry to SHIFT
//   word_rdy  consumer ready for word
//   err_clr   clears sticky ovf/tmo (a same-cycle set wins)
//   busy      high in SHIFT or HOLD
//   shift_en  high when a bit is being accepted this cycle
//   word      captured frame, right-aligned (registered)
//   word_vld  word valid, high in HOLD (registered)
//   ovf       sticky: bit arrived while holding a word
//   tmo       sticky: capture aborted by idle timeout
// -----------------------------------------------------------------------------
module shift_frame_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sdata,
    input  logic        sbit_vld,
    input  logic [4:0]  len,
    input  logic        word_rdy,
    input  logic        err_clr,
    output logic        busy,
    output logic        shift_en,
    output logic [31:0] word,
    output logic        word_vld,
    output logic        ovf,
    output logic        tmo
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    logic [1:0]  state;
    logic [31:0] shadow;
    logic [4:0]  bit_cnt;
    logic [4:0]  len_q;
    logic [7:0]  idle_cnt;

    logic [31:0] shadow_nxt;
    logic [7:0]  idle_nxt;

    always_comb begin
        shadow_nxt = {shadow[30:0], sdata};
        idle_nxt   = idle_cnt + 8'd1;
        busy       = (state == ST_SHIFT) || (state == ST_HOLD);
        // Gated by rst so no shift is advertised in a cycle that resets.
        shift_en   = (state == ST_SHIFT) && sbit_vld && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            shadow   <= '0;
            bit_cnt  <= '0;
            len_q    <= '0;
            idle_cnt <= '0;
            word     <= '0;
            word_vld <= 1'b0;
            ovf      <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            // Clear first; any set below overrides it in the same cycle.
            if (err_clr) begin
                ovf <= 1'b0;
                tmo <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SHIFT;
                        shadow   <= '0;
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                        len_q    <= len;
                    end
                end

                ST_SHIFT: begin
                    if (start) begin
                        // Restart: bit offered in this cycle is discarded.
                        shadow   <= '0;
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                        len_q    <= len;
                    end else if (sbit_vld) begin
                        shadow   <= shadow_nxt;
                        bit_cnt  <= bit_cnt + 5'd1;
                        idle_cnt <= '0;
                        if (bit_cnt == len_q) begin
                            word     <= shadow_nxt;
                            word_vld <= 1'b1;
                            state    <= ST_HOLD;
                        end
                    end else begin
                        idle_cnt <= idle_nxt;
                        if (idle_nxt == TMO_LIM) begin
                            state <= ST_IDLE;
                            tmo   <= 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (sbit_vld) begin
                        ovf <= 1'b1;
                    end
                    if (word_vld && word_rdy) begin
                        word_vld <= 1'b0;
                        if (start) begin
                            state    <= ST_SHIFT;
                            shadow   <= '0;
                            bit_cnt  <= '0;
                            idle_cnt <= '0;
                            len_q    <= len;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_frame_ctrl.sv
module tb_shift_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, sdata, sbit_vld, word_rdy, err_clr;
    logic [4:0]  len;

    logic        busy, shift_en, word_vld, ovf, tmo;
    logic [31:0] word;
    logic        busy2, shift_en2, word_vld2, ovf2, tmo2;
    logic [31:0] word2;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    shift_frame_ctrl #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .sdata(sdata), .sbit_vld(sbit_vld),
        .len(len), .word_rdy(word_rdy), .err_clr(err_clr),
        .busy(busy), .shift_en(shift_en), .word(word), .word_vld(word_vld),
        .ovf(ovf), .tmo(tmo)
    );

    shift_frame_ctrl #(.TIMEOUT(4)) dut_t4 (
        .clk(clk), .rst(rst), .start(start), .sdata(sdata), .sbit_vld(sbit_vld),
        .len(len), .word_rdy(word_rdy), .err_clr(err_clr),
        .busy(busy2), .shift_en(shift_en2), .word(word2), .word_vld(word_vld2),
        .ovf(ovf2), .tmo(tmo2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; sdata = 0; sbit_vld = 0; word_rdy = 0; err_clr = 0;
    endtask

    // Accept one bit; sdata driven, then one clock edge.
    task automatic send_bit(input logic b);
        start = 0; sbit_vld = 1; sdata = b;
        cyc();
        sbit_vld = 0; sdata = 0;
    endtask

    task automatic begin_frame(input logic [4:0] l);
        start = 1; len = l;
        cyc();
        start = 0;
    endtask

    task automatic handshake();
        word_rdy = 1;
        cyc();
        word_rdy = 0;
    endtask

    // Monitor: compare each newly presented word against the scoreboard.
    logic prev_vld = 1'b0;
    always @(negedge clk) begin
        if (word_vld && !prev_vld) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got 0x%08h expected none", word);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (word !== e) begin
                    bad++;
                    $display("FAIL sb_word: got 0x%08h expected 0x%08h", word, e);
                end
            end
        end
        prev_vld <= word_vld;
    end

    initial begin
        logic [7:0]  b8;
        logic [31:0] b32;

        idle_inputs();
        len = 0;
        rst = 1;
        cyc(); cyc();
        rst = 0;
        sbit_vld = 1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_word", word, 0);
        chk("rst_vld", 32'(word_vld), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_tmo", 32'(tmo), 0);
        chk("rst_shift_en", 32'(shift_en), 0);
        sbit_vld = 0;

        // 8-bit frame 0xB2, continuous; start-cycle bit must be ignored.
        exp_q.push_back(32'h0000_00B2);
        start = 1; len = 5'd7; sbit_vld = 1; sdata = 1;
        cyc();
        start = 0;
        chk("b2_busy_start", 32'(busy), 1);
        b8 = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            sbit_vld = 1; sdata = b8[i];
            #1;
            chk("b2_shift_en", 32'(shift_en), 1);
            if (i == 0) chk("b2_vld_before_last", 32'(word_vld), 0);
            cyc();
            chk("b2_busy", 32'(busy), 1);
        end
        sbit_vld = 0;
        chk("b2_vld_latency", 32'(word_vld), 1);
        chk("b2_word", word, 32'h0000_00B2);
        handshake();
        chk("b2_idle_busy", 32'(busy), 0);
        chk("b2_idle_vld", 32'(word_vld), 0);

        // 32-bit frame 0xDEADBEEF with 3-cycle gaps.
        exp_q.push_back(32'hDEAD_BEEF);
        begin_frame(5'd31);
        b32 = 32'hDEAD_BEEF;
        for (int i = 31; i >= 0; i--) begin
            send_bit(b32[i]);
            if (i != 0) begin cyc(); cyc(); cyc(); end
        end
        chk("de_vld", 32'(word_vld), 1);
        chk("de_word", word, 32'hDEAD_BEEF);
        for (int k = 0; k < 10; k++) cyc();
        chk("de_stable_word", word, 32'hDEAD_BEEF);
        chk("de_stable_vld", 32'(word_vld), 1);

        // Bit arriving while holding: overflow, word untouched.
        send_bit(1'b0);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_word", word, 32'hDEAD_BEEF);
        err_clr = 1;
        cyc();
        err_clr = 0;
        chk("ovf_clr", 32'(ovf), 0);
        err_clr = 1; sbit_vld = 1;
        cyc();
        err_clr = 0; sbit_vld = 0;
        chk("ovf_set_wins", 32'(ovf), 1);
        err_clr = 1;
        cyc();
        err_clr = 0;
        handshake();
        chk("de_idle_busy", 32'(busy), 0);

        // 4-bit frame 0xA; start without handshake ignored; then handshake+start.
        exp_q.push_back(32'h0000_000A);
        begin_frame(5'd3);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        start = 1;
        cyc();
        start = 0;
        chk("hold_start_ign_vld", 32'(word_vld), 1);
        chk("hold_start_ign_word", word, 32'h0000_000A);
        exp_q.push_back(32'h0000_0006);
        start = 1; word_rdy = 1; len = 5'd3; sbit_vld = 1; sdata = 1;
        cyc();
        start = 0; word_rdy = 0; sbit_vld = 0;
        chk("hs_start_busy", 32'(busy), 1);
        chk("hs_start_vld", 32'(word_vld), 0);
        chk("hs_start_ovf", 32'(ovf), 1);
        send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        chk("hs_new_word", word, 32'h0000_0006);
        handshake();

        // Single-bit frame (len=0).
        exp_q.push_back(32'h0000_0001);
        begin_frame(5'd0);
        send_bit(1);
        chk("len0_vld", 32'(word_vld), 1);
        handshake();

        // Restart mid-frame; the bit in the restart cycle is discarded.
        exp_q.push_back(32'h0000_005A);
        begin_frame(5'd7);
        send_bit(1); send_bit(1); send_bit(1);
        start = 1; len = 5'd7; sbit_vld = 1; sdata = 1;
        cyc();
        start = 0; sbit_vld = 0;
        b8 = 8'h5A;
        for (int i = 7; i >= 0; i--) send_bit(b8[i]);
        chk("restart_word", word, 32'h0000_005A);
        handshake();

        // Reset mid-SHIFT discards the frame and clears everything.
        begin_frame(5'd7);
        for (int i = 0; i < 5; i++) send_bit(1);
        rst = 1; sbit_vld = 1; sdata = 1;
        #1;
        chk("rst_mid_shift_en", 32'(shift_en), 0);
        cyc();
        rst = 0;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_word", word, 0);
        chk("rst_mid_vld", 32'(word_vld), 0);
        chk("rst_mid_ovf", 32'(ovf), 0);
        chk("rst_mid_shift_en_after", 32'(shift_en), 0);
        sbit_vld = 0;
        exp_q.push_back(32'h0000_00FF);
        begin_frame(5'd7);
        for (int i = 0; i < 8; i++) send_bit(1);
        chk("ff_word", word, 32'h0000_00FF);
        handshake();

        // Timeout: TIMEOUT=4 instance aborts after the 4th idle cycle.
        rst = 1;
        cyc();
        rst = 0;
        begin_frame(5'd7);
        send_bit(1); send_bit(0); send_bit(1);
        cyc(); cyc(); cyc();
        chk("t4_busy_3idle", 32'(busy2), 1);
        chk("t4_tmo_3idle", 32'(tmo2), 0);
        cyc();
        chk("t4_busy", 32'(busy2), 0);
        chk("t4_tmo", 32'(tmo2), 1);
        chk("t4_vld", 32'(word_vld2), 0);
        chk("t4_word", word2, 0);
        chk("t255_busy", 32'(busy), 1);
        chk("t255_tmo", 32'(tmo), 0);
        err_clr = 1;
        cyc();
        err_clr = 0;
        chk("t4_tmo_clr", 32'(tmo2), 0);

        rst = 1;
        cyc();
        rst = 0;
        cyc(); cyc();
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_frame_ctrl.md
SHIFT_FRAME_CTRL -- requirements
Module: shift_frame_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max idle cycles allowed between accepted bits in SHIFT; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a frame capture.
REQ-005 SHALL have port sdata  input  1  serial data bit.
REQ-006 SHALL have port sbit_vld  input  1  qualifies sdata for the current cycle.
REQ-007 SHALL have port len  input  5  frame length minus one (0 = 1 bit, 31 = 32 bits); sampled on entry to SHIFT.
REQ-008 SHALL have port word_rdy  input  1  consumer ready for word.
REQ-009 SHALL have port err_clr  input  1  clears sticky flags.
REQ-010 SHALL have port busy  output  1  high in SHIFT or HOLD.
REQ-011 SHALL have port shift_en  output  1  combinational: high when state is SHIFT and sbit_vld is high.
REQ-012 SHALL have port word  output  32  captured frame, right-aligned.
REQ-013 SHALL have port word_vld  output  1  word valid, high in HOLD.
REQ-014 SHALL have port ovf  output  1  sticky: bit arrived while in HOLD.
REQ-015 SHALL have port tmo  output  1  sticky: capture aborted by timeout.

Function
REQ-016 SHALL implement the three-state FSM IDLE, SHIFT, HOLD.
REQ-017 IDLE -> SHIFT on start: clear the 32-bit shadow register, clear the 5-bit bit counter and the idle counter, latch len; sbit_vld in the start cycle SHALL be ignored.
REQ-018 In SHIFT, each cycle with sbit_vld: shadow <= {shadow[30:0], sdata}; the bit counter increments and the idle counter clears.
REQ-019 When the accepted bit has counter == latched len: word <= updated shadow, and the next state is HOLD; word_vld SHALL rise exactly 1 cycle after the last bit is accepted.
REQ-020 For frames shorter than 32 bits, word[31:len+1] SHALL be 0; the first bit received SHALL be in bit position len.
REQ-021 In SHIFT, each cycle without sbit_vld increments the idle counter; when it reaches TIMEOUT: go to IDLE, set tmo, and leave word and word_vld unchanged.
REQ-022 start in SHIFT SHALL restart the capture (same actions as REQ-017); any sbit_vld in that cycle SHALL be discarded.
REQ-023 HOLD: word and word_vld held stable until a word_vld && word_rdy edge; then next state IDLE, or SHIFT if start is high in the same cycle (REQ-017 actions apply).
REQ-024 In HOLD, start without handshake SHALL be ignored; sbit_vld SHALL set ovf and drop the bit (shadow unchanged).
REQ-025 err_clr SHALL clear ovf and tmo; a same-cycle set SHALL win over the clear.
REQ-026 word_vld and word SHALL be registered outputs; no combinational path from inputs to word_vld.

Reset
REQ-027 rst high at an edge SHALL force state IDLE; word=0, word_vld=0, busy=0, ovf=0, tmo=0; shadow and all counters 0.
REQ-028 rst SHALL override all other inputs in the same cycle, including mid-SHIFT and mid-HOLD; the in-progress frame is discarded.
REQ-029 shift_en SHALL be 0 during and after reset until SHIFT is re-entered.

Verification
REQ-030 len=7, start, then 8 bits 1,0,1,1,0,0,1,0 with sbit_vld continuous -> word=0x000000B2, word_vld high 1 cycle after 8th bit, busy high throughout.
REQ-031 len=31, 32 bits forming 0xDEADBEEF with gaps of 3 cycles between bits, TIMEOUT=255 -> word=0xDEADBEEF; word_rdy held low 10 cycles -> word stable; word_rdy high -> IDLE next cycle, busy=0.
REQ-032 In HOLD, pulse sbit_vld -> ovf=1, word unchanged; err_clr -> ovf=0 next cycle.
REQ-033 TIMEOUT=4, len=7, 3 bits then no sbit_vld -> after 4 idle cycles state IDLE, tmo=1, word_vld=0.
REQ-034 Mid-SHIFT (5 of 8 bits) assert rst for 1 cycle -> all outputs 0; subsequent start plus 8 bits 0xFF -> word=0x000000FF.
REQ-035 Handshake with start high in the same cycle -> next cycle busy=1, word_vld=0, new capture proceeds with no lost bits.
